// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch/decode instruction queue.
package if_id_queue_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned DEPTH_DEF    = 2;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEF_RESET_PC = 32'h4000_0000;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface if_id_queue_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [CW-1:0]   count;

    // Pipeline side driving fetch data, flush and decode acceptance
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, count
    );

    // The queue itself
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Small instruction/PC queue between fetch and decode; shows a NOP bubble when
// empty and drops everything on a redirect.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] NOP      = XLEN'(INSTR_NOP),
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_queue_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic in_ready_c;
    logic out_valid_c;
    logic push_c;
    logic pop_c;

    // Status depends on registered occupancy only, so stallF never sees out_ready
    assign in_ready_c  = (count_q != CW'(DEPTH));
    assign out_valid_c = (count_q != '0);

    assign push_c = bus.in_valid  & in_ready_c  & ~bus.flush;
    assign pop_c  = bus.out_ready & out_valid_c & ~bus.flush;

    // Next-state: storage write, pointer advance, occupancy; flush overrides
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                instr_d[wr_ptr_q] = bus.in_instr;
                pc_d[wr_ptr_q]    = bus.in_pc;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= NOP;
                pc_q[i]    <= RESET_PC;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_instr = out_valid_c ? instr_q[rd_ptr_q] : NOP;
    assign bus.out_pc    = out_valid_c ? pc_q[rd_ptr_q]    : RESET_PC;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h4000_0000;

    logic clk;
    logic rst_n;

    if_id_queue_if #(.XLEN(XLEN), .CW(CW)) bus ();

    if_id_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP), .RESET_PC(RPC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: plain FIFO of {instr, pc}
    logic [63:0] mq [$];

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic [1:0]  e_count;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int sz = mq.size();
        logic [63:0] h = (sz != 0) ? mq[0] : {NOP, RPC};
        check({tag, ".count"},     32'(bus.count),     32'(sz));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sz != 0));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(sz != DEPTH));
        check({tag, ".out_instr"}, bus.out_instr,      h[63:32]);
        check({tag, ".out_pc"},    bus.out_pc,         h[31:0]);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0093} ^ 32'h5A00_0000;
    endfunction

    // One clock: drive, check pre-edge state, advance model, settle past edge
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy, input string tag);
        int sz;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.flush     = fl;
        bus.out_ready = ordy;
        check_model(tag);
        sz = mq.size();
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (ordy && sz > 0) void'(mq.pop_front());
            if (iv && sz < DEPTH) mq.push_back({ins, pc});
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h4000_0000, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4000_0000, 1'b1};
        tbl[1]  = '{1'b1, 32'h4000_0004, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4000_0004, 1'b1};
        tbl[2]  = '{1'b1, 32'h4000_0008, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4000_0008, 1'b1};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, RPC,           1'b1};
        tbl[4]  = '{1'b1, 32'h4000_0000, 1'b0, 1'b0, 2'd1, 1'b1, 32'h4000_0000, 1'b1};
        tbl[5]  = '{1'b1, 32'h4000_0004, 1'b0, 1'b0, 2'd2, 1'b1, 32'h4000_0000, 1'b0};
        tbl[6]  = '{1'b1, 32'h4000_0008, 1'b0, 1'b0, 2'd2, 1'b1, 32'h4000_0000, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4000_0004, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, RPC,           1'b1};
        tbl[9]  = '{1'b1, 32'h4000_0010, 1'b0, 1'b0, 2'd1, 1'b1, 32'h4000_0010, 1'b1};
        tbl[10] = '{1'b1, 32'h4000_0014, 1'b0, 1'b0, 2'd2, 1'b1, 32'h4000_0010, 1'b0};
        tbl[11] = '{1'b1, 32'h4000_0018, 1'b1, 1'b1, 2'd0, 1'b0, RPC,           1'b1};
        tbl[12] = '{1'b1, 32'h4000_0100, 1'b0, 1'b0, 2'd1, 1'b1, 32'h4000_0100, 1'b1};
        tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, RPC,           1'b1};
        tbl[14] = '{1'b1, 32'h4000_0020, 1'b0, 1'b0, 2'd1, 1'b1, 32'h4000_0020, 1'b1};
        tbl[15] = '{1'b1, 32'h4000_0024, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4000_0024, 1'b1};
        tbl[16] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, RPC,           1'b1};
        tbl[17] = '{1'b1, 32'h4000_0030, 1'b0, 1'b0, 2'd1, 1'b1, 32'h4000_0030, 1'b1};
        tbl[18] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 1'b0, RPC,           1'b1};

        // Power-on reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: streaming, decode stall, flush while full, push+pop at count 1
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].iv, instr_of(tbl[i].pc), tbl[i].pc, tbl[i].fl, tbl[i].ordy,
                  $sformatf("tbl%0d.pre", i));
            check($sformatf("tbl%0d.count", i),     32'(bus.count),     32'(tbl[i].e_count));
            check($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d.out_pc", i),    bus.out_pc,         tbl[i].e_pc);
            check($sformatf("tbl%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d.out_instr", i), bus.out_instr,
                  tbl[i].e_valid ? instr_of(tbl[i].e_pc) : NOP);
        end

        // Asynchronous reset mid-cycle while holding two entries
        cycle(1'b1, instr_of(32'h4000_0040), 32'h4000_0040, 1'b0, 1'b0, "arst.fill0");
        cycle(1'b1, instr_of(32'h4000_0044), 32'h4000_0044, 1'b0, 1'b0, "arst.fill1");
        check("arst.full_count", 32'(bus.count), 32'd2);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check("arst.count",     32'(bus.count),     32'd0);
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.out_instr", bus.out_instr,      NOP);
        check("arst.out_pc",    bus.out_pc,         RPC);
        check("arst.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap-around: alternating push/pop, strict ordering via the model
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc = 32'h4000_0200 + 32'(i * 4);
            cycle(1'b1, instr_of(pc), pc, 1'b0, 1'b0, $sformatf("wrap%0d.push", i));
            check($sformatf("wrap%0d.head", i), bus.out_pc, pc);
            cycle(1'b0, '0, '0, 1'b0, 1'b1, $sformatf("wrap%0d.pop", i));
        end

        // Randomized traffic including flushes
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc = $urandom;
            cycle(($urandom % 4) != 0, $urandom, pc, ($urandom % 16) == 0,
                  ($urandom % 3) != 0, "rand");
        end
        idle_inputs();
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
